// File: rtl/alu_if.sv
// ALU operand/result bundle shared between the EX stage and the ALU.
interface alu_if;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  alu_control;
    logic [31:0] result;
    logic        zero;
    logic        overflow;
    logic [31:0] result_q;
    logic        zero_q;
    logic        overflow_q;

    // Pipeline side: drives operands and op select, observes results.
    modport master (
        output a,
        output b,
        output alu_control,
        input  result,
        input  zero,
        input  overflow,
        input  result_q,
        input  zero_q,
        input  overflow_q
    );

    // ALU side.
    modport slave (
        input  a,
        input  b,
        input  alu_control,
        output result,
        output zero,
        output overflow,
        output result_q,
        output zero_q,
        output overflow_q
    );
endinterface

// File: rtl/alu.sv
// 32-bit MIPS EX-stage ALU: combinational result/zero/overflow plus a
// registered copy of all three for the downstream stage and debug.
module alu (
    input  logic   clk,
    input  logic   rst_n,
    alu_if.slave   bus
);

    localparam logic [3:0] OpAnd  = 4'b0000;
    localparam logic [3:0] OpOr   = 4'b0001;
    localparam logic [3:0] OpAdd  = 4'b0010;
    localparam logic [3:0] OpAddu = 4'b0011;
    localparam logic [3:0] OpSubu = 4'b0100;
    localparam logic [3:0] OpSub  = 4'b0110;
    localparam logic [3:0] OpSlt  = 4'b0111;
    localparam logic [3:0] OpSll  = 4'b1000;
    localparam logic [3:0] OpSltu = 4'b1001;
    localparam logic [3:0] OpSrl  = 4'b1010;
    localparam logic [3:0] OpSra  = 4'b1011;
    localparam logic [3:0] OpNor  = 4'b1100;
    localparam logic [3:0] OpXor  = 4'b1101;

    logic [31:0] sum;
    logic [31:0] diff;
    logic [4:0]  shamt;
    logic        add_ovf;
    logic        sub_ovf;

    logic [31:0] result_d;
    logic        zero_d;
    logic        overflow_d;
    logic [31:0] result_q;
    logic        zero_q;
    logic        overflow_q;

    // Shared adder/subtractor outputs and their signed-overflow conditions.
    always_comb begin
        sum     = bus.a + bus.b;
        diff    = bus.a - bus.b;
        shamt   = bus.a[4:0];
        add_ovf = (bus.a[31] == bus.b[31]) && (sum[31] != bus.a[31]);
        sub_ovf = (bus.a[31] != bus.b[31]) && (diff[31] != bus.a[31]);
    end

    // Operation decode; undefined codes fall to the zero/no-overflow default.
    always_comb begin
        result_d   = '0;
        overflow_d = 1'b0;
        case (bus.alu_control)
            OpAnd:  result_d = bus.a & bus.b;
            OpOr:   result_d = bus.a | bus.b;
            OpAdd: begin
                result_d   = sum;
                overflow_d = add_ovf;
            end
            OpAddu: result_d = sum;
            OpSub: begin
                result_d   = diff;
                overflow_d = sub_ovf;
            end
            OpSubu: result_d = diff;
            OpXor:  result_d = bus.a ^ bus.b;
            OpNor:  result_d = ~(bus.a | bus.b);
            // True signed compare, so it stays correct when a - b overflows.
            OpSlt:  result_d = {31'b0, $signed(bus.a) < $signed(bus.b)};
            OpSltu: result_d = {31'b0, bus.a < bus.b};
            OpSll:  result_d = bus.b << shamt;
            OpSrl:  result_d = bus.b >> shamt;
            OpSra:  result_d = $unsigned($signed(bus.b) >>> shamt);
            default: begin
                result_d   = '0;
                overflow_d = 1'b0;
            end
        endcase
        zero_d = (result_d == '0);
    end

    // Capture the combinational outputs every cycle; reset clears only these.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q   <= '0;
            zero_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            result_q   <= result_d;
            zero_q     <= zero_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.result     = result_d;
    assign bus.zero       = zero_d;
    assign bus.overflow   = overflow_d;
    assign bus.result_q   = result_q;
    assign bus.zero_q     = zero_q;
    assign bus.overflow_q = overflow_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vectors plus random vectors against
// a reference model; registered outputs checked through an expectation queue.
module tb_alu;

    logic clk;
    logic rst_n;

    alu_if bus ();

    alu u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic        zero;
        logic        ovf;
    } exp_t;

    exp_t exp_q[$];

    int checks;
    int failures;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference model, written independently of the RTL structure.
    function automatic exp_t model(input logic [3:0] ctl, input logic [31:0] a,
                                   input logic [31:0] b);
        exp_t        e;
        logic [32:0] wide;
        logic [63:0] ext;
        int          sh;
        sh    = int'(a[4:0]);
        e.res = 32'h0;
        e.ovf = 1'b0;
        case (ctl)
            4'b0000: e.res = a & b;
            4'b0001: e.res = a | b;
            4'b0010, 4'b0011: begin
                wide  = {a[31], a} + {b[31], b};
                e.res = wide[31:0];
                if (ctl == 4'b0010) e.ovf = wide[32] ^ wide[31];
            end
            4'b0110, 4'b0100: begin
                wide  = {a[31], a} - {b[31], b};
                e.res = wide[31:0];
                if (ctl == 4'b0110) e.ovf = wide[32] ^ wide[31];
            end
            4'b1101: e.res = a ^ b;
            4'b1100: e.res = ~(a | b);
            4'b0111: e.res = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            4'b1001: e.res = ({1'b0, a} < {1'b0, b}) ? 32'd1 : 32'd0;
            4'b1000: e.res = b << sh;
            4'b1010: e.res = b >> sh;
            4'b1011: begin
                ext   = {{32{b[31]}}, b} >> sh;
                e.res = ext[31:0];
            end
            default: e.res = 32'h0;
        endcase
        e.zero = (e.res == 32'h0);
        return e;
    endfunction

    // Drive one op between edges, check combinational outputs, queue the
    // expectation, then pop and check the registered copy after the edge.
    task automatic run_op(input string tag, input logic [3:0] ctl, input logic [31:0] a,
                          input logic [31:0] b, input exp_t e);
        exp_t got_e;
        @(negedge clk);
        bus.alu_control = ctl;
        bus.a           = a;
        bus.b           = b;
        #1;
        check_eq({tag, ".result"},   bus.result,          e.res);
        check_eq({tag, ".zero"},     {31'b0, bus.zero},     {31'b0, e.zero});
        check_eq({tag, ".overflow"}, {31'b0, bus.overflow}, {31'b0, e.ovf});
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check_eq({tag, ".queue_empty"}, 32'd0, 32'd1);
        end else begin
            got_e = exp_q.pop_front();
            check_eq({tag, ".result_q"},   bus.result_q,          got_e.res);
            check_eq({tag, ".zero_q"},     {31'b0, bus.zero_q},     {31'b0, got_e.zero});
            check_eq({tag, ".overflow_q"}, {31'b0, bus.overflow_q}, {31'b0, got_e.ovf});
        end
    endtask

    task automatic run_dir(input string tag, input logic [3:0] ctl, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] res, input logic ovf);
        exp_t e;
        e.res  = res;
        e.ovf  = ovf;
        e.zero = (res == 32'h0);
        run_op(tag, ctl, a, b, e);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        bus.a           = 32'd10;
        bus.b           = 32'd5;
        bus.alu_control = 4'b0010;

        // Registers held clear through several edges while in reset.
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst.result_q",   bus.result_q,            32'h0);
        check_eq("rst.zero_q",     {31'b0, bus.zero_q},     32'h0);
        check_eq("rst.overflow_q", {31'b0, bus.overflow_q}, 32'h0);
        check_eq("rst.comb_result", bus.result,             32'd15);

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("rel.result_q_hold", bus.result_q, 32'h0);

        run_dir("add",        4'b0010, 32'd10,        32'd5,         32'd15,        1'b0);
        run_dir("addu_wrap",  4'b0011, 32'hFFFFFFFF,  32'd1,         32'h0,         1'b0);
        run_dir("add_ovf",    4'b0010, 32'h7FFFFFFF,  32'd1,         32'h80000000,  1'b1);
        run_dir("addu_noovf", 4'b0011, 32'h7FFFFFFF,  32'd1,         32'h80000000,  1'b0);
        run_dir("add_negneg", 4'b0010, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFE,  1'b0);
        run_dir("sub",        4'b0110, 32'd10,        32'd15,        32'hFFFFFFFB,  1'b0);
        run_dir("subu",       4'b0100, 32'd10,        32'd15,        32'hFFFFFFFB,  1'b0);
        run_dir("sub_ovf",    4'b0110, 32'h80000000,  32'd1,         32'h7FFFFFFF,  1'b1);
        run_dir("subu_noovf", 4'b0100, 32'h80000000,  32'd1,         32'h7FFFFFFF,  1'b0);
        run_dir("and",        4'b0000, 32'hF0F0F0F0,  32'h0F0F0F0F,  32'h0,         1'b0);
        run_dir("or",         4'b0001, 32'hF0F0F0F0,  32'h0F0F0F0F,  32'hFFFFFFFF,  1'b0);
        run_dir("xor",        4'b1101, 32'hFF00FF00,  32'h00FF00FF,  32'hFFFFFFFF,  1'b0);
        run_dir("nor",        4'b1100, 32'h0,         32'hFFFFFFFF,  32'h0,         1'b0);
        run_dir("slt_neg",    4'b0111, 32'hFFFFFFFB,  32'd3,         32'd1,         1'b0);
        run_dir("sltu",       4'b1001, 32'hFFFFFFFE,  32'd2,         32'd0,         1'b0);
        run_dir("slt_ovf",    4'b0111, 32'h80000000,  32'h7FFFFFFF,  32'd1,         1'b0);
        run_dir("sll",        4'b1000, 32'd3,         32'd1,         32'd8,         1'b0);
        run_dir("srl",        4'b1010, 32'd3,         32'h80000000,  32'h10000000,  1'b0);
        run_dir("sra",        4'b1011, 32'd3,         32'hFFFFFFF0,  32'hFFFFFFFE,  1'b0);
        run_dir("sll_hi_amt", 4'b1000, 32'h23,        32'd1,         32'd8,         1'b0);
        run_dir("sra_zero",   4'b1011, 32'h0,         32'h80000001,  32'h80000001,  1'b0);
        run_dir("sra_31",     4'b1011, 32'd31,        32'h80000000,  32'hFFFFFFFF,  1'b0);
        run_dir("undef_0101", 4'b0101, 32'h7FFFFFFF,  32'd1,         32'h0,         1'b0);
        run_dir("undef_1110", 4'b1110, 32'h12345678,  32'h9ABCDEF0,  32'h0,         1'b0);
        run_dir("undef_1111", 4'b1111, 32'h80000000,  32'h80000000,  32'h0,         1'b0);

        // Random operands across every code, checked against the model.
        for (int i = 0; i < 64; i++) begin
            logic [3:0]  ctl;
            logic [31:0] ra;
            logic [31:0] rb;
            ctl = 4'(i % 16);
            ra  = $urandom();
            rb  = $urandom();
            if (i % 5 == 0) rb = ra;
            run_op("rand", ctl, ra, rb, model(ctl, ra, rb));
        end

        // Reset asserted between edges clears the registers at once.
        run_dir("pre_rst", 4'b0010, 32'd10, 32'd5, 32'd15, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("midrst.result_q",    bus.result_q,            32'h0);
        check_eq("midrst.zero_q",      {31'b0, bus.zero_q},     32'h0);
        check_eq("midrst.overflow_q",  {31'b0, bus.overflow_q}, 32'h0);
        check_eq("midrst.comb_result", bus.result,              32'd15);
        @(posedge clk);
        #1;
        check_eq("midrst.hold", bus.result_q, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu.md
# alu

Combinational 32-bit integer ALU for the EX stage of the MIPS pipeline, executing the R-type/I-type arithmetic, logic, compare and shift operations selected by a 4-bit control code from the ALU control unit. The combinational `result` feeds the EX/MEM path and forwarding with zero latency. The block also provides a registered copy of result and status flags, clocked on the pipeline clock, for the downstream stage and debug.

## Interface
- No parameters; data width fixed at 32 bits.
- One clock; reset is asynchronous and active-low.
- `clk` input, 1 bit: pipeline clock, rising-edge active.
- `rst_n` input, 1 bit: asynchronous active-low reset, registered outputs only.
- `a` input, 32 bits: operand A (rs); for shifts, `a[4:0]` is the shift amount.
- `b` input, 32 bits: operand B (rt or immediate); for shifts, the value shifted.
- `alu_control` input, 4 bits: operation select.
- `result` output, 32 bits: combinational result.
- `zero` output, 1 bit: combinational, 1 when `result == 0`.
- `overflow` output, 1 bit: combinational signed overflow, ADD/SUB only.
- `result_q` output, 32 bits: `result` registered.
- `zero_q` output, 1 bit: `zero` registered.
- `overflow_q` output, 1 bit: `overflow` registered.

## Operation
- Encoding of `alu_control`, with the resulting `result`:
  - 0000 AND: a & b
  - 0001 OR: a | b
  - 0010 ADD: a + b, mod 2^32
  - 0011 ADDU: a + b, mod 2^32
  - 0110 SUB: a − b, mod 2^32
  - 0100 SUBU: a − b, mod 2^32
  - 1101 XOR: a ^ b
  - 1100 NOR: ~(a | b)
  - 0111 SLT: {31'b0, signed(a) < signed(b)}
  - 1001 SLTU: {31'b0, unsigned(a) < unsigned(b)}
  - 1000 SLL: b << a[4:0]
  - 1010 SRL: b >> a[4:0], zero fill
  - 1011 SRA: b >>> a[4:0], sign fill from b[31]
- Undefined codes 0101, 1110, 1111: `result` = 0 and `overflow` = 0.
- `a[31:5]` is ignored for shifts. A shift of 0 returns `b` unchanged.
- `overflow` rules:
  - ADD: set when a[31] == b[31] and result[31] != a[31].
  - SUB: set when a[31] != b[31] and result[31] != a[31].
  - Forced 0 for every other code, including ADDU and SUBU.
  - The result still wraps; trapping is the control path's job.
- SLT compares the true signed values, not the sign of a − b, so it is correct under overflow.
- `zero` is derived from `result` for every code, including undefined codes (zero = 1 there).

## Timing
- `result`, `zero` and `overflow` are purely combinational: no latency, no state, valid within the same cycle as the inputs.
- On every rising `clk` edge, `result_q`, `zero_q` and `overflow_q` capture their combinational counterparts. Latency is 1 cycle, with no enable and no stall input.
- While `rst_n` = 0, asynchronously and regardless of `clk`: `result_q` = 0, `zero_q` = 0, `overflow_q` = 0.
- On `rst_n` rising, registers hold reset values until the next rising `clk` edge.
- Reset asserted mid-operation clears the registers immediately. Combinational outputs are unaffected by reset.
- Inputs changing together with the clock edge: the registers capture the pre-edge combinational value.

## Test plan
- ADD/ADDU:
  - a=10, b=5, ctl=0010 → result=15, zero=0, overflow=0.
  - a=0xFFFFFFFF, b=1, ctl=0011 → result=0, zero=1, overflow=0.
  - a=0x7FFFFFFF, b=1, ctl=0010 → result=0x80000000, overflow=1.
- SUB/SUBU: a=10, b=15 with ctl=0110 and ctl=0100 → result=0xFFFFFFFB (−5) both; overflow=0.
- Logic:
  - AND 0xF0F0F0F0 & 0x0F0F0F0F → 0, zero=1.
  - OR of same → 0xFFFFFFFF.
  - XOR 0xFF00FF00 ^ 0x00FF00FF → 0xFFFFFFFF.
  - NOR 0 with 0xFFFFFFFF → 0.
- Compare:
  - SLT a=−5, b=3 → 1.
  - SLTU a=0xFFFFFFFE, b=2 → 0.
  - SLT a=0x80000000, b=0x7FFFFFFF → 1.
- Shifts, a=3:
  - SLL b=1 → 8.
  - SRL b=0x80000000 → 0x10000000.
  - SRA b=0xFFFFFFF0 → 0xFFFFFFFE.
  - a=0x23 (shift 3) behaves like a=3.
- Registers:
  - Hold `rst_n` = 0 → all `_q` outputs 0.
  - Release reset, apply ADD 10+5 → `result_q`=15 after the next rising edge.
  - Assert `rst_n` low between edges → `result_q` = 0 immediately.
